rec0101_table_scanner: RTL and testbench

//  Sequential tester for 4-input combinational function blocks. It sweeps all 16 vectors
//  {x,y,w,z}, samples the DUT output s after a settle delay and builds a 16-bit truth table.
//  It then compares that table with an expected constant and reports pass/fail, mismatch

---
 rtl/rec0101_table_scanner.sv | 142 ++++++++++++++
 tb/tb_rec0101_table_scanner.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rec0101_table_scanner.sv
// Truth-table scanner: sweeps {x,y,w,z} through an external 4-input block, captures s_in
// per vector and compares against EXPECTED. Optional macro: SCAN_STOP_ON_ERR_EN (early exit).
//
// state  | meaning
// IDLE   | vec parked at 0, results held, waiting for start
// WAIT   | vector driven, settle counter running down
// SAMPLE | capture s_in for current vec, update mismatch bookkeeping
// DONE   | one-cycle wrap-up: pulse done, resolve pass, park vec
module rec0101_table_scanner #(
    parameter logic [15:0] EXPECTED      = 16'h7310,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [3:0]  vec,
    input  logic        s_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] table_out,
    output logic [4:0]  mismatch_cnt,
    output logic [3:0]  first_err,
    output logic        first_err_vld
);

    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  vec_d;
    logic [15:0] tbl_d;
    logic [4:0]  mc_d;
    logic [3:0]  fe_d;
    logic        fev_d;
    logic        pass_d;
    logic        done_d;
    logic        mism;

    assign mism = (s_in != EXPECTED[vec]);
    assign busy = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            vec           <= '0;
            table_out     <= '0;
            mismatch_cnt  <= '0;
            first_err     <= '0;
            first_err_vld <= 1'b0;
            pass          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            vec           <= vec_d;
            table_out     <= tbl_d;
            mismatch_cnt  <= mc_d;
            first_err     <= fe_d;
            first_err_vld <= fev_d;
            pass          <= pass_d;
            done          <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec;
        tbl_d   = table_out;
        mc_d    = mismatch_cnt;
        fe_d    = first_err;
        fev_d   = first_err_vld;
        pass_d  = pass;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                vec_d = '0;
                if (start) begin
                    tbl_d   = '0;
                    mc_d    = '0;
                    fe_d    = '0;
                    fev_d   = 1'b0;
                    pass_d  = 1'b0;
                    cnt_d   = SETTLE;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                tbl_d[vec] = s_in;
                if (mism) begin
                    mc_d = mismatch_cnt + 5'd1;
                    if (!first_err_vld) begin
                        fe_d  = vec;
                        fev_d = 1'b1;
                    end
                end
`ifdef SCAN_STOP_ON_ERR_EN
                if (mism || vec == 4'd15) begin
                    state_d = DONE;
                end else begin
                    vec_d   = vec + 4'd1;
                    cnt_d   = SETTLE;
                    state_d = WAIT;
                end
`else
                if (vec == 4'd15) begin
                    state_d = DONE;
                end else begin
                    vec_d   = vec + 4'd1;
                    cnt_d   = SETTLE;
                    state_d = WAIT;
                end
`endif
            end
            DONE: begin
                // mismatch_cnt is already final here: the last SAMPLE update has landed
                done_d  = 1'b1;
                pass_d  = (mismatch_cnt == 5'd0);
                vec_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rec0101_table_scanner.sv
// Bench for rec0101_table_scanner: emulated 4-input blocks, truth-table level reference model,
// per-cycle protocol compare plus literal result checks.
module tb_rec0101_table_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  vec;
    logic        s_in;
    logic        busy, done, pass;
    logic [15:0] table_out;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_err;
    logic        first_err_vld;

    logic        start3 = 1'b0;
    logic [3:0]  vec3;
    logic        s3, d1, d2;
    logic        busy3, done3, pass3;
    logic [15:0] table3;
    logic [4:0]  mc3;
    logic [3:0]  fe3;
    logic        fev3;

    logic [15:0] cur_tt = 16'h0;
    logic [15:0] gold;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    bit          active = 0;
    bit          chk_en = 0;

    int          m_nvec;
    logic [15:0] m_tbl;
    int          m_mc;
    int          m_fe;
    bit          m_fev;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign s_in = cur_tt[vec];

    // slow block for the SETTLE_CYCLES=3 instance: golden function behind two registers
    always @(posedge clk) begin
        d1 <= gold[vec3];
        d2 <= d1;
    end
    assign s3 = d2;

    rec0101_table_scanner dut (
        .clk(clk), .reset(reset), .start(start), .vec(vec), .s_in(s_in),
        .busy(busy), .done(done), .pass(pass), .table_out(table_out),
        .mismatch_cnt(mismatch_cnt), .first_err(first_err), .first_err_vld(first_err_vld)
    );

    rec0101_table_scanner #(.EXPECTED(16'h7310), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .vec(vec3), .s_in(s3),
        .busy(busy3), .done(done3), .pass(pass3), .table_out(table3),
        .mismatch_cnt(mc3), .first_err(fe3), .first_err_vld(fev3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic sop(input int v);
        logic x, y, w, z;
        x = v[3]; y = v[2]; w = v[1]; z = v[0];
        return (x & ~w) | (y & ~w & ~z) | (x & y & ~z);
    endfunction

    // outcome of scanning a block whose truth table is tt
    task automatic model(input logic [15:0] tt);
        int mask;
        m_nvec = 16; m_mc = 0; m_fe = 0; m_fev = 0;
        for (int v = 0; v < 16; v++) begin
            if (v < m_nvec && tt[v] != gold[v]) begin
                if (!m_fev) begin
                    m_fe  = v;
                    m_fev = 1;
                end
                m_mc++;
`ifdef SCAN_STOP_ON_ERR_EN
                m_nvec = v + 1;
`endif
            end
        end
        mask  = (m_nvec == 16) ? 32'hFFFF : ((1 << m_nvec) - 1);
        m_tbl = tt & mask[15:0];
    endtask

    // protocol compare: done/busy/vec on every cycle from the scan's start time
    always @(negedge clk) begin
        if (chk_en) begin
            int r, rd, ev;
            logic eb, ed;
            if (active) begin
                r  = cyc - start_cyc;
                rd = 2 + m_nvec * 2;
                ed = (r == rd);
                eb = (r >= 1 && r < rd);
                ev = eb ? (((r - 1) / 2 > m_nvec - 1) ? m_nvec - 1 : (r - 1) / 2) : 0;
            end else begin
                ed = 1'b0; eb = 1'b0; ev = 0;
            end
            chk("done_cyc", 32'(done), 32'(ed));
            chk("busy_cyc", 32'(busy), 32'(eb));
            chk("vec_cyc", 32'(vec), ev);
        end
    end

    task automatic run_scan(input logic [15:0] tt, input int poke_r, input int rst_r);
        bit got;
        int rd;
        got = 0;
        model(tt);
        cur_tt = tt;
        rd = 2 + m_nvec * 2;
        @(posedge clk); #1;
        start_cyc = cyc;
        active = 1;
        start = 1'b1;
        for (int i = 1; i <= rd + 3; i++) begin
            @(posedge clk); #1;
            start = (i == poke_r);
            if (rst_r > 0 && i == rst_r + 1) begin
                reset = 1'b0;
                active = 0;
                chk("rst_busy", 32'(busy), 0);
                chk("rst_done", 32'(done), 0);
                chk("rst_pass", 32'(pass), 0);
                chk("rst_table", 32'(table_out), 0);
                chk("rst_mc", 32'(mismatch_cnt), 0);
                chk("rst_fe", 32'(first_err), 0);
                chk("rst_fev", 32'(first_err_vld), 0);
                chk("rst_vec", 32'(vec), 0);
                break;
            end
            if (rst_r > 0 && i == rst_r) begin
                chk("vec_before_rst", 32'(vec), 7);
                reset = 1'b1;
            end
            if (done === 1'b1 && !got) begin
                got = 1;
                chk("res_table", 32'(table_out), 32'(m_tbl));
                chk("res_mc", 32'(mismatch_cnt), m_mc);
                chk("res_fe", 32'(first_err), m_fe);
                chk("res_fev", 32'(first_err_vld), 32'(m_fev));
                chk("res_pass", 32'(pass), 32'(m_mc == 0));
            end
            if (i == rd + 3) begin
                chk("hold_table", 32'(table_out), 32'(m_tbl));
                chk("hold_mc", 32'(mismatch_cnt), m_mc);
                chk("hold_pass", 32'(pass), 32'(m_mc == 0));
            end
        end
        if (rst_r == 0 && !got) chk("done_timeout", 0, 1);
    endtask

    task automatic run_slow;
        bit got;
        int k;
        got = 0;
        @(posedge clk); #1;
        k = cyc;
        start3 = 1'b1;
        for (int i = 1; i <= 80 && !got; i++) begin
            @(posedge clk); #1;
            start3 = 1'b0;
            if (done3 === 1'b1) begin
                got = 1;
                chk("slow_done_cycle", cyc - k, 66);
                chk("slow_pass", 32'(pass3), 1);
                chk("slow_table", 32'(table3), 32'h7310);
            end
        end
        if (!got) chk("slow_timeout", 0, 1);
    endtask

    initial begin
        for (int v = 0; v < 16; v++) gold[v] = sop(v);
        m_nvec = 16;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_table", 32'(table_out), 0);
        chk("reset_vec", 32'(vec), 0);
        reset = 1'b0;
        chk_en = 1;

        run_scan(gold, 0, 0);
        chk("t1_table_lit", 32'(table_out), 32'h7310);
        chk("t1_pass_lit", 32'(pass), 1);
        chk("t1_fev_lit", 32'(first_err_vld), 0);

        run_scan(~gold, 0, 0);
        chk("t2_fe_lit", 32'(first_err), 0);
        chk("t2_fev_lit", 32'(first_err_vld), 1);
`ifndef SCAN_STOP_ON_ERR_EN
        chk("t2_table_lit", 32'(table_out), 32'h8CEF);
        chk("t2_mc_lit", 32'(mismatch_cnt), 16);
`endif

        run_scan(16'h0000, 0, 0);
        chk("t3_table_lit", 32'(table_out), 0);
        chk("t3_fe_lit", 32'(first_err), 4);
        chk("t3_pass_lit", 32'(pass), 0);
`ifdef SCAN_STOP_ON_ERR_EN
        chk("t3_mc_lit", 32'(mismatch_cnt), 1);
`else
        chk("t3_mc_lit", 32'(mismatch_cnt), 6);
`endif

        run_scan(gold, 11, 0);
        run_scan(gold, 0, 15);
        repeat (4) @(posedge clk);
        run_scan(gold, 0, 0);
        chk("t5_pass_lit", 32'(pass), 1);

        run_slow();

        for (int n = 0; n < 12; n++) begin
            logic [15:0] rt;
            rt = 16'($urandom);
            if ($urandom_range(0, 3) == 0) rt = gold;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_scan(rt, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
